// File: rtl/mux_arb_pkg.sv
// Shared encodings for the 4-requester round-robin word arbiter.
package mux_arb_pkg;
  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_e;
endpackage

// File: rtl/mux_4x1_nbits.sv
// Plain 4:1 word mux; select index is {s1,s0}.
module mux_4x1_nbits #(
  parameter int bits = 16
) (
  input  logic [bits-1:0] x0,
  input  logic [bits-1:0] x1,
  input  logic [bits-1:0] x2,
  input  logic [bits-1:0] x3,
  input  logic            s0,
  input  logic            s1,
  output logic [bits-1:0] y
);
  always_comb begin
    unique case ({s1, s0})
      2'd0:    y = x0;
      2'd1:    y = x1;
      2'd2:    y = x2;
      default: y = x3;
    endcase
  end
endmodule

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first set request scanning upward from ptr.
module rr_pick_4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       winner,
  output logic             any
);
  always_comb begin
    logic [1:0] idx;
    idx    = '0;
    winner = '0;
    // Scan from the farthest slot down so the nearest set request wins last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) winner = idx;
    end
  end

  assign any = |req;
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 word mux among four requesters, with a
// single-entry valid/ready output buffer and bounded bursts per grant.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int bits  = 16,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [bits-1:0]  x0,
  input  logic [bits-1:0]  x1,
  input  logic [bits-1:0]  x2,
  input  logic [bits-1:0]  x3,
  input  logic             out_ready,
  output logic [N_REQ-1:0] gnt,
  output logic             s0,
  output logic             s1,
  output logic [bits-1:0]  out_data,
  output logic             out_valid,
  output logic             busy
);
  localparam int            CW      = $clog2(BURST + 1);
  localparam logic [CW:0]   BURST_W = (CW + 1)'(BURST);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       win_q, win_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW:0]      cnt_inc;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [bits-1:0]  data_q, data_d;
  logic             valid_q, valid_d;
  logic [1:0]       pick;
  logic             pick_any;
  logic [bits-1:0]  mux_y;

  rr_pick_4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick),
    .any    (pick_any)
  );

  mux_4x1_nbits #(.bits(bits)) u_mux (
    .x0 (x0),
    .x1 (x1),
    .x2 (x2),
    .x3 (x3),
    .s0 (win_q[0]),
    .s1 (win_q[1]),
    .y  (mux_y)
  );

  assign cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = N_REQ'(1) << pick;
          win_d   = pick;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        data_d  = mux_y;
        valid_d = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          cnt_d   = cnt_inc[CW-1:0];
          valid_d = 1'b0;
          // A dropped request still gets its captured word; only the next one is skipped.
          if (req[win_q] && (cnt_inc < BURST_W)) begin
            state_d = ST_LOAD;
          end else begin
            gnt_d   = '0;
            ptr_d   = win_q + 2'd1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign s0        = win_q[0];
  assign s1        = win_q[1];
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench: BURST=4 instance for bursts/back-pressure/reset, BURST=1 for rotation.
module tb_mux4_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] x0, x1, x2, x3;
  logic        out_ready;

  logic [3:0]  gnt_a, gnt_b;
  logic        s0_a, s1_a, s0_b, s1_b;
  logic [15:0] data_a, data_b;
  logic        valid_a, valid_b, busy_a, busy_b;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.bits(16), .BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .out_ready(out_ready), .gnt(gnt_a), .s0(s0_a), .s1(s1_a),
    .out_data(data_a), .out_valid(valid_a), .busy(busy_a)
  );

  mux4_rr_arbiter #(.bits(16), .BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .out_ready(out_ready), .gnt(gnt_b), .s0(s0_b), .s1(s1_b),
    .out_data(data_b), .out_valid(valid_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] s,
                       input logic [15:0] d, input logic v, input logic b);
    chk({tag, ".gnt"},   32'(gnt_a),         32'(g));
    chk({tag, ".sel"},   32'({s1_a, s0_a}),  32'(s));
    chk({tag, ".data"},  32'(data_a),        32'(d));
    chk({tag, ".valid"}, 32'(valid_a),       32'(v));
    chk({tag, ".busy"},  32'(busy_a),        32'(b));
  endtask

  initial begin
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b0; req = '0; out_ready = 1'b0;
    x0 = 16'h1234; x1 = 16'hBEEF; x2 = 16'hA5A5; x3 = 16'h7E7E;

    // 1: reset state and idle hold
    do_reset();
    chk_a("rst", 4'b0000, 2'b00, 16'h0000, 1'b0, 1'b0);
    chk("rst.b_gnt", 32'(gnt_b), 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle.gnt", 32'(gnt_a), 32'h0);
      chk("idle.busy", 32'(busy_a), 32'h0);
    end

    // 2: single requester, full burst of 4 then release, ptr -> 3
    req = 4'b0100; out_ready = 1'b1;
    tick();
    chk_a("arb2", 4'b0100, 2'b10, 16'h0000, 1'b0, 1'b1);
    for (int w = 0; w < 4; w++) begin
      tick();
      chk_a("word2", 4'b0100, 2'b10, 16'hA5A5, 1'b1, 1'b1);
      tick();
      if (w < 3) chk_a("next2", 4'b0100, 2'b10, 16'hA5A5, 1'b0, 1'b1);
      else       chk("rel2.gnt", 32'(gnt_a), 32'h0);
    end
    chk("rel2.busy", 32'(busy_a), 32'h0);
    req = 4'b1111;
    tick();
    chk("ptr3.gnt", 32'(gnt_a), 32'(4'b1000));
    chk("ptr3.sel", 32'({s1_a, s0_a}), 32'(2'b11));

    // 3: BURST=1 rotation with wrap, all requesting
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rot.gnt", 32'(gnt_b), 32'(order[k]));
      tick();
      chk("rot.valid", 32'(valid_b), 32'h1);
      tick();
    end

    // 4: back-pressure holds word, grant and valid
    do_reset();
    req = 4'b0001; out_ready = 1'b0;
    tick();
    tick();
    chk_a("bp.first", 4'b0001, 2'b00, 16'h1234, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a("bp.hold", 4'b0001, 2'b00, 16'h1234, 1'b1, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp.acc.valid", 32'(valid_a), 32'h0);
    chk("bp.acc.gnt", 32'(gnt_a), 32'(4'b0001));

    // 5: req[1] drops during SEND of word 2; word still delivered, then release, ptr -> 2
    do_reset();
    req = 4'b0010; out_ready = 1'b1;
    tick();
    chk("drop.arb", 32'(gnt_a), 32'(4'b0010));
    tick();
    chk("drop.w1", 32'(data_a), 32'hBEEF);
    tick();
    tick();
    chk_a("drop.w2", 4'b0010, 2'b01, 16'hBEEF, 1'b1, 1'b1);
    req = 4'b0000; out_ready = 1'b0;
    tick();
    chk_a("drop.kept", 4'b0010, 2'b01, 16'hBEEF, 1'b1, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("drop.rel.gnt", 32'(gnt_a), 32'h0);
    chk("drop.rel.valid", 32'(valid_a), 32'h0);
    req = 4'b1111;
    tick();
    chk("ptr2.gnt", 32'(gnt_a), 32'(4'b0100));

    // 6: async reset mid-SEND, then ptr back to 0
    do_reset();
    req = 4'b0001; out_ready = 1'b0;
    tick();
    tick();
    chk("pre.valid", 32'(valid_a), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk_a("async", 4'b0000, 2'b00, 16'h0000, 1'b0, 1'b0);
    #1 rst = 1'b0;
    req = 4'b1010;
    tick();
    chk("post.gnt", 32'(gnt_a), 32'(4'b0010));
    chk("post.sel", 32'({s1_a, s0_a}), 32'(2'b01));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
